// File: rtl/ysyx_wbu_if.sv
// Writeback stage bus: the execute-side handshake with the instruction payload,
// the retire/commit side, and the register-file, redirect and halt outputs.
// The stage drives the bus through the slave modport and its driver or
// environment through the master modport.
interface ysyx_wbu_if #(
  parameter int unsigned BIT_W = 32,
  parameter int unsigned CNT_W = 32
) ();

  // Execute-stage handshake and instruction payload
  logic             prev_valid;
  logic             ready_o;
  logic [31:0]      inst_i;
  logic [BIT_W-1:0] pc_i;
  logic [BIT_W-1:0] reg_wdata_i;
  logic [3:0]       rd_i;
  logic [BIT_W-1:0] npc_wdata_i;
  logic             use_exu_npc_i;
  logic             ebreak_i;

  // Retire sink backpressure
  logic             commit_ready_i;

  // Register file write port
  logic             rf_wen_o;
  logic [3:0]       rf_waddr_o;
  logic [BIT_W-1:0] rf_wdata_o;

  // Fetch redirect
  logic             redirect_o;
  logic [BIT_W-1:0] redirect_pc_o;

  // Retire reporting and halt
  logic             retire_valid_o;
  logic [BIT_W-1:0] retire_pc_o;
  logic [31:0]      retire_inst_o;
  logic [CNT_W-1:0] retire_cnt_o;
  logic             halt_o;

  modport slave (
    input  prev_valid,
    input  inst_i,
    input  pc_i,
    input  reg_wdata_i,
    input  rd_i,
    input  npc_wdata_i,
    input  use_exu_npc_i,
    input  ebreak_i,
    input  commit_ready_i,
    output ready_o,
    output rf_wen_o,
    output rf_waddr_o,
    output rf_wdata_o,
    output redirect_o,
    output redirect_pc_o,
    output retire_valid_o,
    output retire_pc_o,
    output retire_inst_o,
    output retire_cnt_o,
    output halt_o
  );

  modport master (
    output prev_valid,
    output inst_i,
    output pc_i,
    output reg_wdata_i,
    output rd_i,
    output npc_wdata_i,
    output use_exu_npc_i,
    output ebreak_i,
    output commit_ready_i,
    input  ready_o,
    input  rf_wen_o,
    input  rf_waddr_o,
    input  rf_wdata_o,
    input  redirect_o,
    input  redirect_pc_o,
    input  retire_valid_o,
    input  retire_pc_o,
    input  retire_inst_o,
    input  retire_cnt_o,
    input  halt_o
  );

endinterface

// File: rtl/ysyx_wbu.sv
// Writeback/retire stage. Completed instructions from execute are buffered in
// a small FIFO and the head retires at most one per cycle: it writes the
// register file, may redirect fetch (flushing every younger instruction) and
// may halt the core on ebreak. Also counts retired instructions.
// DEPTH must be a power of two and at least 2 so the pointers wrap for free.
module ysyx_wbu #(
  parameter int unsigned BIT_W = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 32
) (
  input logic       clk,
  input logic       rst,
  ysyx_wbu_if.slave wbu
);

  localparam int unsigned PtrW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CountW = PtrW + 1;
  localparam logic [CountW-1:0] FullCount = CountW'(DEPTH);

  typedef struct packed {
    logic [31:0]      inst;
    logic [BIT_W-1:0] pc;
    logic [BIT_W-1:0] wdata;
    logic [3:0]       rd;
    logic [BIT_W-1:0] npc;
    logic             use_npc;
    logic             ebreak;
  } entry_t;

  typedef enum logic [0:0] {
    StRun,
    StHalt
  } state_e;

  entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CountW-1:0]  count_q, count_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  state_e             state_q, state_d;
  logic               ready_q, ready_d;

  entry_t head;
  entry_t in_entry;
  logic   head_valid;
  logic   enq;
  logic   retire;
  logic   flush;

  // Pack the incoming instruction into one FIFO entry
  always_comb begin
    in_entry         = '0;
    in_entry.inst    = wbu.inst_i;
    in_entry.pc      = wbu.pc_i;
    in_entry.wdata   = wbu.reg_wdata_i;
    in_entry.rd      = wbu.rd_i;
    in_entry.npc     = wbu.npc_wdata_i;
    in_entry.use_npc = wbu.use_exu_npc_i;
    in_entry.ebreak  = wbu.ebreak_i;
  end

  // Handshake and retire decisions for this cycle
  always_comb begin
    head       = mem_q[rd_ptr_q];
    head_valid = (count_q != '0);
    retire     = head_valid & wbu.commit_ready_i & (state_q == StRun);
    // Redirect and ebreak both kill everything younger than the head,
    // including whatever is being handed over this very cycle.
    flush      = retire & (head.use_npc | head.ebreak);
    // ready_q is registered, so enqueue never depends on commit_ready_i.
    enq        = wbu.prev_valid & ready_q;
  end

  // Next-state for FIFO, retire counter, FSM and registered ready
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    cnt_d    = cnt_q;
    state_d  = state_q;

    if (retire) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (flush) begin
      // Empty the FIFO by snapping the read pointer onto the write pointer.
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (enq) begin
        mem_d[wr_ptr_q] = in_entry;
        wr_ptr_d        = wr_ptr_q + PtrW'(1);
      end
      if (retire) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      count_d = count_q + CountW'(enq) - CountW'(retire);
    end

    if (retire && head.ebreak) begin
      state_d = StHalt;
    end

    ready_d = (state_d == StRun) & (count_d < FullCount);
  end

  // State registers; ready resets low so it is deasserted while in reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      cnt_q    <= '0;
      state_q  <= StRun;
      ready_q  <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      ready_q  <= ready_d;
    end
  end

  // Output drive: retire side is combinational from the FIFO head
  always_comb begin
    wbu.ready_o        = ready_q;
    wbu.retire_valid_o = retire;
    wbu.retire_pc_o    = head.pc;
    wbu.retire_inst_o  = head.inst;
    wbu.rf_wen_o       = retire & (head.rd != 4'd0);
    wbu.rf_waddr_o     = head.rd;
    wbu.rf_wdata_o     = head.wdata;
    wbu.redirect_o     = retire & head.use_npc;
    wbu.redirect_pc_o  = head.npc;
    wbu.retire_cnt_o   = cnt_q;
    wbu.halt_o         = (state_q == StHalt);
  end

endmodule
